// File: rtl/pcs_fifo_wr_ctrl.sv
// Write-side pointer controller for the 16-entry dual-clock PCS receive elastic FIFO.
// Owns the Gray write pointer, synchronizes the read pointer in, and registers full/level status.
module pcs_fifo_wr_ctrl #(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W:0]   rd_gptr_async,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W:0]   wr_gptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              ovf_err
);

    localparam int unsigned      PW        = ADDR_W + 1;
    localparam logic [ADDR_W:0]  AFULL_LVL = PW'(AFULL_THRESH);

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    logic [ADDR_W:0]                     wr_bin;
    logic [SYNC_STAGES-1:0][ADDR_W:0]    sync_q;
    logic [ADDR_W:0]                     rd_gsync;
    logic [ADDR_W:0]                     rd_bsync;
    logic                                accept;
    logic [ADDR_W:0]                     wr_bin_nxt;
    logic [ADDR_W:0]                     wr_gptr_nxt;
    logic [ADDR_W:0]                     level_nxt;
    logic                                full_nxt;
    logic                                afull_nxt;
    logic                                ovf_nxt;

    // rd_gptr_async is sampled only by the first synchronizer stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rd_gptr_async};
        end
    end

    assign rd_gsync = sync_q[SYNC_STAGES-1];
    assign rd_bsync = gray2bin(rd_gsync);

    // reset_n and flush both veto the write so no RAM write lands during either
    assign accept    = wr_valid & ~full & ~flush & reset_n;
    assign ram_we    = accept;
    assign ram_waddr = wr_bin[ADDR_W-1:0];
    assign wr_ready  = ~full;

    always_comb begin
        wr_bin_nxt  = wr_bin;
        wr_gptr_nxt = '0;
        level_nxt   = '0;
        full_nxt    = 1'b0;
        afull_nxt   = 1'b0;
        ovf_nxt     = 1'b0;
        if (flush) begin
            wr_bin_nxt = '0;
        end else begin
            wr_bin_nxt = wr_bin + PW'(accept);
        end
        wr_gptr_nxt = bin2gray(wr_bin_nxt);
        if (!flush) begin
            full_nxt  = (wr_gptr_nxt == {~rd_gsync[ADDR_W:ADDR_W-1], rd_gsync[ADDR_W-2:0]});
            level_nxt = wr_bin_nxt - rd_bsync;
            afull_nxt = (level_nxt >= AFULL_LVL);
            ovf_nxt   = ovf_err | (wr_valid & full);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bin      <= '0;
            wr_gptr     <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            level       <= '0;
            ovf_err     <= 1'b0;
        end else begin
            wr_bin      <= wr_bin_nxt;
            wr_gptr     <= wr_gptr_nxt;
            full        <= full_nxt;
            almost_full <= afull_nxt;
            level       <= level_nxt;
            ovf_err     <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_pcs_fifo_wr_ctrl.sv
// Self-checking bench for pcs_fifo_wr_ctrl: expected RAM write addresses are queued
// when writes are driven and compared by a monitor when ram_we is observed.
module tb_pcs_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] rd_gptr_async;
    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [4:0] wr_gptr;
    logic       full;
    logic       almost_full;
    logic [4:0] level;
    logic       ovf_err;

    int errors = 0;
    int checks = 0;
    logic [3:0] addr_q[$];
    logic [3:0] exp_addr;

    pcs_fifo_wr_ctrl #(
        .ADDR_W(4),
        .SYNC_STAGES(2),
        .AFULL_THRESH(12)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .rd_gptr_async(rd_gptr_async),
        .ram_we(ram_we),
        .ram_waddr(ram_waddr),
        .wr_gptr(wr_gptr),
        .full(full),
        .almost_full(almost_full),
        .level(level),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input int unsigned b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && ram_we === 1'b1) begin
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ram_we: ram_waddr=%0d, no write expected", ram_waddr);
            end else begin
                exp_addr = addr_q.pop_front();
                if (ram_waddr !== exp_addr) begin
                    errors++;
                    $display("FAIL ram_waddr: got %0d expected %0d", ram_waddr, exp_addr);
                end
            end
        end
    end

    task automatic test_reset;
        reset_n = 1'b0; flush = 1'b0; wr_valid = 1'b1; rd_gptr_async = '0;
        tick; tick;
        checks++;
        if ({wr_ready, ram_we, full, almost_full, ovf_err, wr_gptr, level} !== {5'b10000, 5'd0, 5'd0}) begin
            errors++;
            $display("FAIL in_reset: rdy=%b we=%b full=%b af=%b ovf=%b gptr=%b lvl=%0d expected rdy=1 rest 0",
                     wr_ready, ram_we, full, almost_full, ovf_err, wr_gptr, level);
        end
        wr_valid = 1'b0;
        reset_n  = 1'b1;
        tick;
        checks++;
        if ({wr_ready, ram_we, full, almost_full, ovf_err, wr_gptr, level} !== {5'b10000, 5'd0, 5'd0}) begin
            errors++;
            $display("FAIL after_reset: rdy=%b we=%b full=%b af=%b ovf=%b gptr=%b lvl=%0d expected rdy=1 rest 0",
                     wr_ready, ram_we, full, almost_full, ovf_err, wr_gptr, level);
        end
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr_q.push_back(4'(i));
            tick;
        end
        checks++;
        if (wr_gptr !== gray(3) || level !== 5'd3) begin
            errors++;
            $display("FAIL burst3: gptr=%b lvl=%0d expected gptr=%b lvl=3", wr_gptr, level, gray(3));
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (wr_gptr !== 5'd0 || ram_we !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: gptr=%b we=%b lvl=%0d expected all 0", wr_gptr, ram_we, level);
        end
        wr_valid = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_fill;
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr_q.push_back(4'(i));
            tick;
            checks++;
            if (level !== 5'(i + 1)) begin
                errors++;
                $display("FAIL fill_level: got %0d expected %0d", level, i + 1);
            end
            if (i == 10) begin
                checks++;
                if (almost_full !== 1'b0) begin
                    errors++;
                    $display("FAIL afull_11: got %b expected 0", almost_full);
                end
            end
            if (i == 11) begin
                checks++;
                if (almost_full !== 1'b1) begin
                    errors++;
                    $display("FAIL afull_12: got %b expected 1", almost_full);
                end
            end
            if (i == 14) begin
                checks++;
                if (full !== 1'b0 || wr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL full_15: full=%b rdy=%b expected full=0 rdy=1", full, wr_ready);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || wr_ready !== 1'b0 || wr_gptr !== 5'b11000) begin
            errors++;
            $display("FAIL full_16: full=%b rdy=%b gptr=%b expected full=1 rdy=0 gptr=11000",
                     full, wr_ready, wr_gptr);
        end
    endtask

    task automatic test_overflow;
        #3;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL ovf_we: ram_we=%b expected 0", ram_we);
        end
        tick;
        checks++;
        if (ovf_err !== 1'b1 || wr_gptr !== 5'b11000 || level !== 5'd16) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b gptr=%b lvl=%0d expected ovf=1 gptr=11000 lvl=16",
                     ovf_err, wr_gptr, level);
        end
        wr_valid = 1'b0;
        tick; tick;
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf_err);
        end
    endtask

    task automatic test_drain;
        rd_gptr_async = 5'b00110;
        tick; tick;
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL drain_latency: full=%b expected 1 before sync completes", full);
        end
        tick;
        checks++;
        if (level !== 5'd12 || full !== 1'b0 || wr_ready !== 1'b1 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL drain_seen: lvl=%0d full=%b rdy=%b af=%b expected lvl=12 full=0 rdy=1 af=1",
                     level, full, wr_ready, almost_full);
        end
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(4'(i));
            tick;
        end
        wr_valid = 1'b0;
        checks++;
        if (full !== 1'b1 || wr_gptr !== 5'b11110 || level !== 5'd16 || ram_waddr !== 4'd4) begin
            errors++;
            $display("FAIL refill: full=%b gptr=%b lvl=%0d waddr=%0d expected full=1 gptr=11110 lvl=16 waddr=4",
                     full, wr_gptr, level, ram_waddr);
        end
    endtask

    task automatic test_flush_ovf;
        flush = 1'b1;
        rd_gptr_async = '0;
        tick;
        flush = 1'b0;
        checks++;
        if (ovf_err !== 1'b0 || wr_gptr !== 5'd0 || level !== 5'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: ovf=%b gptr=%b lvl=%0d full=%b expected all 0",
                     ovf_err, wr_gptr, level, full);
        end
        tick; tick; tick;
        checks++;
        if (level !== 5'd0 || almost_full !== 1'b0 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_settle: lvl=%0d af=%b ovf=%b expected all 0", level, almost_full, ovf_err);
        end
    endtask

    task automatic test_track;
        int unsigned rd_hist[0:100];
        int unsigned exp_level;
        logic [4:0]  prev;
        rd_hist[0] = 0;
        wr_valid = 1'b1;
        for (int m = 1; m <= 100; m++) begin
            prev = wr_gptr;
            addr_q.push_back(4'(m - 1));
            tick;
            rd_hist[m] = (m >= 3) ? m - 3 : 0;
            rd_gptr_async = gray(rd_hist[m]);
            exp_level = m - ((m >= 3) ? rd_hist[m - 3] : 0);
            checks++;
            if (wr_gptr !== gray(m)) begin
                errors++;
                $display("FAIL track_gptr: write %0d gptr=%b expected %b", m, wr_gptr, gray(m));
            end
            checks++;
            if ($countones(wr_gptr ^ prev) != 1) begin
                errors++;
                $display("FAIL track_onebit: write %0d gptr %b -> %b, expected one bit change", m, prev, wr_gptr);
            end
            checks++;
            if (level !== 5'(exp_level) || level < 5'd1 || level > 5'd6) begin
                errors++;
                $display("FAIL track_level: write %0d lvl=%0d expected %0d", m, level, exp_level);
            end
            checks++;
            if (full !== 1'b0 || almost_full !== 1'b0) begin
                errors++;
                $display("FAIL track_full: write %0d full=%b af=%b expected 0", m, full, almost_full);
            end
        end
    endtask

    task automatic test_flush_write;
        flush = 1'b1;
        rd_gptr_async = '0;
        #3;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_we: ram_we=%b expected 0", ram_we);
        end
        tick;
        flush = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if (wr_gptr !== 5'd0 || level !== 5'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL flush_write: gptr=%b lvl=%0d full=%b expected all 0", wr_gptr, level, full);
        end
        tick;
        checks++;
        if (addr_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: %0d expected writes never seen, expected 0", addr_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_overflow;
        test_drain;
        test_flush_ovf;
        test_track;
        test_flush_write;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
